// File: rtl/div_unit.sv
// div_unit: iterative radix-2 restoring divider for div.w / mod.w / div.wu / mod.wu.
// Holds one result until the consumer takes it; flush cancels any work in flight.
module div_unit #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        req_op,
    input  logic [DATA_W-1:0] req_src1,
    input  logic [DATA_W-1:0] req_src2,
    input  logic              flush,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_result,
    output logic              busy
);
    localparam int CW = $clog2(DATA_W) + 1;
    localparam logic [DATA_W-1:0] MIN_NEG = {1'b1, {(DATA_W-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t            r_state, w_next;
    logic [CW-1:0]     r_cnt;
    logic              r_sel_rem, r_neg_q, r_neg_r;
    logic [DATA_W-1:0] r_dvd, r_dvs, r_quo, r_rem, r_result;

    logic              w_fire, w_signed, w_s1_neg, w_s2_neg, w_div0, w_ovf, w_early, w_sel_rem;
    logic [DATA_W-1:0] w_abs1, w_abs2, w_early_res;
    logic [DATA_W:0]   w_rem_sh, w_diff;
    logic              w_ge, w_last;
    logic [DATA_W-1:0] w_rem_nx, w_quo_nx, w_q_fix, w_r_fix, w_fin;

    assign w_fire      = req_valid && req_ready;
    assign w_signed    = req_op[0] | req_op[1];
    assign w_sel_rem   = req_op[1] | req_op[3];
    assign w_s1_neg    = w_signed & req_src1[DATA_W-1];
    assign w_s2_neg    = w_signed & req_src2[DATA_W-1];
    assign w_abs1      = w_s1_neg ? -req_src1 : req_src1;
    assign w_abs2      = w_s2_neg ? -req_src2 : req_src2;
    assign w_div0      = req_src2 == '0;
    assign w_ovf       = w_signed && req_src1 == MIN_NEG && req_src2 == '1;
    assign w_early     = w_div0 || w_ovf;
    // Early-out results bypass the loop and need no sign fix-up.
    assign w_early_res = w_sel_rem ? (w_div0 ? req_src1 : '0) : (w_div0 ? '1 : MIN_NEG);

    // One restoring step; the borrow of the DATA_W+1-bit subtract is the compare result.
    assign w_rem_sh = {r_rem, r_dvd[DATA_W-1]};
    assign w_diff   = w_rem_sh - {1'b0, r_dvs};
    assign w_ge     = !w_diff[DATA_W];
    assign w_rem_nx = w_ge ? w_diff[DATA_W-1:0] : w_rem_sh[DATA_W-1:0];
    assign w_quo_nx = {r_quo[DATA_W-2:0], w_ge};
    assign w_last   = r_cnt == CW'(1);
    assign w_q_fix  = r_neg_q ? -w_quo_nx : w_quo_nx;
    assign w_r_fix  = r_neg_r ? -w_rem_nx : w_rem_nx;
    assign w_fin    = r_sel_rem ? w_r_fix : w_q_fix;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = flush ? S_IDLE :
                 (r_state == S_IDLE && w_fire) ? (w_early ? S_DONE : S_BUSY) :
                 (r_state == S_BUSY && w_last) ? S_DONE :
                 (r_state == S_DONE && resp_ready) ? S_IDLE : r_state;
    end

    always_comb begin
        req_ready  = (r_state == S_IDLE) && !flush;
        busy       = r_state != S_IDLE;
        resp_valid = r_state == S_DONE;
    end

    assign resp_result = r_result;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt     <= '0;
            r_sel_rem <= 1'b0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_dvd     <= '0;
            r_dvs     <= '0;
            r_quo     <= '0;
            r_rem     <= '0;
            r_result  <= '0;
        end else if (flush) begin
            r_cnt <= '0;
        end else if (w_fire) begin
            r_cnt     <= CW'(DATA_W);
            r_sel_rem <= w_sel_rem;
            r_neg_q   <= w_s1_neg ^ w_s2_neg;
            r_neg_r   <= w_s1_neg;
            r_dvd     <= w_abs1;
            r_dvs     <= w_abs2;
            r_quo     <= '0;
            r_rem     <= '0;
            if (w_early)
                r_result <= w_early_res;
        end else if (r_state == S_BUSY) begin
            r_cnt <= r_cnt - CW'(1);
            r_dvd <= r_dvd << 1;
            r_rem <= w_rem_nx;
            r_quo <= w_quo_nx;
            if (w_last)
                r_result <= w_fin;
        end
    end
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: random and directed checks of div_unit against a plain-arithmetic reference.
module tb_div_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [3:0]  req_op = 4'b0001;
    logic [31:0] req_src1 = '0;
    logic [31:0] req_src2 = '0;
    logic        flush = 1'b0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_result;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [31:0] MINV = 32'h8000_0000;

    div_unit #(.DATA_W(32)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_src1(req_src1), .req_src2(req_src2), .flush(flush),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_result(resp_result),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic is_rem, is_signed;
        is_rem    = op[1] | op[3];
        is_signed = op[0] | op[1];
        if (b == 0) return is_rem ? a : 32'hFFFF_FFFF;
        if (is_signed && a == MINV && b == 32'hFFFF_FFFF) return is_rem ? 32'h0 : MINV;
        if (is_signed) return is_rem ? 32'($signed(a) % $signed(b)) : 32'($signed(a) / $signed(b));
        return is_rem ? a % b : a / b;
    endfunction

    function automatic int exp_lat(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        return (b == 0 || ((op[0] | op[1]) && a == MINV && b == 32'hFFFF_FFFF)) ? 1 : 33;
    endfunction

    // Inputs change 1 time unit after a rising edge; outputs are sampled there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int hold);
        int n;
        check({tag, "_rdy"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_op = op; req_src1 = a; req_src2 = b;
        tick();
        req_valid = 1'b0;
        req_src1 = $urandom; req_src2 = $urandom;
        n = 1;
        while (!resp_valid && n < 60) begin
            tick();
            n++;
        end
        check({tag, "_lat"}, 32'(n), 32'(exp_lat(op, a, b)));
        check({tag, "_res"}, resp_result, exp);
        for (int i = 0; i < hold; i++) begin
            tick();
            check({tag, "_hold"}, {resp_result[31:2], resp_valid, req_ready}, {exp[31:2], 2'b10});
        end
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        check({tag, "_post"}, {30'd0, resp_valid, req_ready}, {30'd0, 2'b01});
    endtask

    task automatic start_long();
        req_valid = 1'b1; req_op = 4'b0100; req_src1 = 32'h1234_5678; req_src2 = 32'h0000_0123;
        tick();
        req_valid = 1'b0;
    endtask

    initial begin
        logic [3:0]  op;
        logic [31:0] a, b;
        int          seen;
        #2;
        check("reset", {resp_result[31:3], req_ready, resp_valid, busy}, {29'd0, 3'b100});
        tick();
        rst = 1'b0;
        tick();

        do_op("divw",   4'b0001, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 0);
        do_op("modw",   4'b0010, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 0);
        do_op("divwu",  4'b0100, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 0);
        do_op("modwu",  4'b1000, 32'hFFFF_FFF9, 32'd2, 32'h0000_0001, 0);
        do_op("div0",   4'b0001, 32'd5, 32'd0, 32'hFFFF_FFFF, 0);
        do_op("mod0",   4'b0010, 32'd5, 32'd0, 32'h0000_0005, 0);
        do_op("ovfdiv", 4'b0001, MINV, 32'hFFFF_FFFF, MINV, 0);
        do_op("ovfmod", 4'b0010, MINV, 32'hFFFF_FFFF, 32'h0, 0);
        do_op("bigdvs", 4'b0100, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1, 0);
        do_op("bp",     4'b0001, 32'd1000, 32'hFFFF_FFF9, 32'hFFFF_FF72, 10);
        do_op("b2b",    4'b1000, 32'd1000, 32'd7, 32'd6, 0);

        start_long();
        repeat (14) tick();
        flush = 1'b1;
        #1;
        check("flush_rdy", 32'(req_ready), 32'd0);
        tick();
        flush = 1'b0;
        check("flush_idle", {30'd0, busy, resp_valid}, 32'd0);
        seen = 0;
        repeat (40) begin
            tick();
            seen += int'(resp_valid);
        end
        check("flush_novalid", 32'(seen), 32'd0);
        do_op("afterflush", 4'b0100, 32'd100, 32'd7, 32'd14, 0);

        req_valid = 1'b1; flush = 1'b1; req_op = 4'b0001; req_src1 = 32'd9; req_src2 = 32'd3;
        tick();
        req_valid = 1'b0; flush = 1'b0;
        check("flush_req", 32'(busy), 32'd0);

        req_valid = 1'b1; req_op = 4'b0001; req_src1 = 32'd9; req_src2 = 32'd0;
        tick();
        req_valid = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_done", {30'd0, busy, resp_valid}, 32'd0);

        start_long();
        repeat (10) tick();
        #3;
        rst = 1'b1;
        #1;
        check("async_rst", {resp_result[31:3], req_ready, resp_valid, busy}, {29'd0, 3'b100});
        tick();
        rst = 1'b0;
        tick();

        for (int i = 0; i < 40; i++) begin
            op = 4'b0001 << $urandom_range(0, 3);
            a  = $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: b = $urandom_range(1, 20);
                2: begin a = MINV; b = 32'hFFFF_FFFF; end
                3: b = -32'($urandom_range(1, 20));
                default: b = $urandom;
            endcase
            do_op("rand", op, a, b, model(op, a, b), $urandom_range(0, 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
